// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: controller states, digit
// width and the per-digit rollover limits derived from the time moduli.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam int CS_MOD  = 100;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  // Every units digit rolls over after 9; tens digits roll over at modulus/10 - 1.
  localparam logic [DIGIT_W-1:0] LIMIT_UNIT  = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] LIMIT_CS_T  = DIGIT_W'(CS_MOD / 10 - 1);
  localparam logic [DIGIT_W-1:0] LIMIT_SEC_T = DIGIT_W'(SEC_MOD / 10 - 1);
  localparam logic [DIGIT_W-1:0] LIMIT_MIN_T = DIGIT_W'(MIN_MOD / 10 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_u;
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_u;
    logic [DIGIT_W-1:0] cs_t;
    logic [DIGIT_W-1:0] cs_u;
  } bcd_time_t;

endpackage

// File: rtl/stopwatch_core_if.sv
// Bundle between the stopwatch core and its surroundings: the 100 Hz
// reference, the three button pulses, and the digits/flags for the display.
interface stopwatch_core_if;

  logic                            clk_100;
  logic                            start_stop;
  logic                            lap;
  logic                            clear;
  logic [stopwatch_pkg::DIGIT_W-1:0] min_t;
  logic [stopwatch_pkg::DIGIT_W-1:0] min_u;
  logic [stopwatch_pkg::DIGIT_W-1:0] sec_t;
  logic [stopwatch_pkg::DIGIT_W-1:0] sec_u;
  logic [stopwatch_pkg::DIGIT_W-1:0] cs_t;
  logic [stopwatch_pkg::DIGIT_W-1:0] cs_u;
  logic                            running;
  logic                            lap_active;
  logic                            wrap;

  modport master (
    output clk_100, start_stop, lap, clear,
    input  min_t, min_u, sec_t, sec_u, cs_t, cs_u, running, lap_active, wrap
  );

  modport slave (
    input  clk_100, start_stop, lap, clear,
    output min_t, min_u, sec_t, sec_u, cs_t, cs_u, running, lap_active, wrap
  );

endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD counter digit. Counts when enabled, rolls over to zero after MAX
// and signals the rollover combinationally so digits can be chained.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = LIMIT_UNIT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_en,
  output logic [DIGIT_W-1:0] o_value,
  output logic               o_carry
);

  logic [DIGIT_W-1:0] r_value;

  // Digit register: zeroed by reset or clear, otherwise steps on its carry-in.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_value <= '0;
    end else if (i_en) begin
      r_value <= (r_value == MAX) ? '0 : r_value + DIGIT_W'(1);
    end
  end

  assign o_value = r_value;
  assign o_carry = i_en && (r_value == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: detects rising edges of the 100 Hz reference, counts
// MM:SS.cc in BCD while running, and handles run/pause/lap/clear control.
module stopwatch_core
  import stopwatch_pkg::*;
(
  input  logic             clk_in,
  input  logic             res,
  stopwatch_core_if.slave  bus
);

  logic      r_prev;
  logic      w_tick;
  logic      w_count_en;
  logic      w_clear_cnt;
  logic      w_lap_capture;
  state_t    r_state;
  state_t    w_next;
  bcd_time_t w_count;
  bcd_time_t r_lap;
  bcd_time_t w_disp;
  logic      w_carry_cs_u;
  logic      w_carry_cs_t;
  logic      w_carry_sec_u;
  logic      w_carry_sec_t;
  logic      w_carry_min_u;
  logic      w_carry_min_t;
  logic      r_wrap;
  logic      r_running;
  logic      r_lap_active;

  // Remember last sample of the 100 Hz reference for rising-edge detection.
  always_ff @(posedge clk_in) begin
    if (res) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= bus.clk_100;
    end
  end

  assign w_tick     = bus.clk_100 & ~r_prev;
  assign w_count_en = w_tick && ((r_state == RUN) || (r_state == LAP));

  // Next-state decode; start_stop outranks clear, which outranks lap.
  always_comb begin
    w_next        = r_state;
    w_lap_capture = 1'b0;
    w_clear_cnt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_stop) w_next = RUN;
      end
      RUN: begin
        if (bus.start_stop) begin
          w_next = PAUSE;
        end else if (bus.lap) begin
          w_next        = LAP;
          w_lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (bus.start_stop)  w_next = PAUSE;
        else if (bus.lap)    w_next = RUN;
      end
      PAUSE: begin
        if (bus.start_stop) begin
          w_next = RUN;
        end else if (bus.clear) begin
          w_next      = IDLE;
          w_clear_cnt = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk_in) begin
    if (res) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  bcd_digit #(.MAX(LIMIT_UNIT)) u_cs_u (
    .i_clk(clk_in), .i_rst(res), .i_clear(w_clear_cnt), .i_en(w_count_en),
    .o_value(w_count.cs_u), .o_carry(w_carry_cs_u)
  );
  bcd_digit #(.MAX(LIMIT_CS_T)) u_cs_t (
    .i_clk(clk_in), .i_rst(res), .i_clear(w_clear_cnt), .i_en(w_carry_cs_u),
    .o_value(w_count.cs_t), .o_carry(w_carry_cs_t)
  );
  bcd_digit #(.MAX(LIMIT_UNIT)) u_sec_u (
    .i_clk(clk_in), .i_rst(res), .i_clear(w_clear_cnt), .i_en(w_carry_cs_t),
    .o_value(w_count.sec_u), .o_carry(w_carry_sec_u)
  );
  bcd_digit #(.MAX(LIMIT_SEC_T)) u_sec_t (
    .i_clk(clk_in), .i_rst(res), .i_clear(w_clear_cnt), .i_en(w_carry_sec_u),
    .o_value(w_count.sec_t), .o_carry(w_carry_sec_t)
  );
  bcd_digit #(.MAX(LIMIT_UNIT)) u_min_u (
    .i_clk(clk_in), .i_rst(res), .i_clear(w_clear_cnt), .i_en(w_carry_sec_t),
    .o_value(w_count.min_u), .o_carry(w_carry_min_u)
  );
  bcd_digit #(.MAX(LIMIT_MIN_T)) u_min_t (
    .i_clk(clk_in), .i_rst(res), .i_clear(w_clear_cnt), .i_en(w_carry_min_u),
    .o_value(w_count.min_t), .o_carry(w_carry_min_t)
  );

  // Lap register holds the count as it stood before any same-cycle increment.
  always_ff @(posedge clk_in) begin
    if (res) begin
      r_lap <= '0;
    end else if (w_lap_capture) begin
      r_lap <= w_count;
    end
  end

  // Status flags follow the state being entered; wrap marks the rollover cycle.
  always_ff @(posedge clk_in) begin
    if (res) begin
      r_wrap       <= 1'b0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
    end else begin
      r_wrap       <= w_carry_min_t;
      r_running    <= (w_next == RUN) || (w_next == LAP);
      r_lap_active <= (w_next == LAP);
    end
  end

  // The display selects between two register banks only, so no logic cone
  // other than the state-driven select sits between flops and the digits.
  assign w_disp = r_lap_active ? r_lap : w_count;

  assign bus.min_t      = w_disp.min_t;
  assign bus.min_u      = w_disp.min_u;
  assign bus.sec_t      = w_disp.sec_t;
  assign bus.sec_u      = w_disp.sec_u;
  assign bus.cs_t       = w_disp.cs_t;
  assign bus.cs_u       = w_disp.cs_u;
  assign bus.running    = r_running;
  assign bus.lap_active = r_lap_active;
  assign bus.wrap       = r_wrap;

endmodule
